// File: rtl/alu_serial.sv
// Bit-serial WIDTH-bit ALU. Operands are consumed LSB first, one bit per clock,
// with a single registered carry and a Start/Busy/Done handshake.
module alu_serial #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] X,
  output logic             C_out,
  output logic             V,
  output logic             Zero,
  output logic             Err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [2:0] M_ADD  = 3'b000;
  localparam logic [2:0] M_AND  = 3'b001;
  localparam logic [2:0] M_OR   = 3'b010;
  localparam logic [2:0] M_XOR  = 3'b011;
  localparam logic [2:0] M_XNOR = 3'b100;
  localparam logic [2:0] M_SUB  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
  logic [2:0]       mode_reg;
  logic             carry_reg, carry_next, bit_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] x_reg;
  logic             c_out_reg, v_reg, zero_reg, err_reg;
  logic             is_arith, is_reserved;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (Start) state_next = S_RUN;
      S_RUN:   if (cnt_reg == LAST_BIT) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state_reg)
      S_RUN:   Busy = 1'b1;
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  // One bit of the operation; logic modes never propagate a carry
  always_comb begin
    bit_next   = 1'b0;
    carry_next = 1'b0;
    case (mode_reg)
      M_ADD, M_SUB: begin
        bit_next   = a_reg[0] ^ b_reg[0] ^ carry_reg;
        carry_next = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));
      end
      M_AND:   bit_next = a_reg[0] & b_reg[0];
      M_OR:    bit_next = a_reg[0] | b_reg[0];
      M_XOR:   bit_next = a_reg[0] ^ b_reg[0];
      M_XNOR:  bit_next = ~(a_reg[0] ^ b_reg[0]);
      default: ;
    endcase
  end

  assign res_next    = {bit_next, res_reg[WIDTH-1:1]};
  assign is_arith    = (mode_reg == M_ADD) || (mode_reg == M_SUB);
  assign is_reserved = mode_reg[2] & mode_reg[1];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      mode_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      x_reg     <= '0;
      c_out_reg <= 1'b0;
      v_reg     <= 1'b0;
      zero_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Start) begin
            // SUB is A + ~B + 1: invert B here and seed the carry with 1
            a_reg     <= A;
            b_reg     <= (Mode == M_SUB) ? ~B : B;
            mode_reg  <= Mode;
            carry_reg <= (Mode == M_ADD) ? C_in : (Mode == M_SUB);
            cnt_reg   <= '0;
            res_reg   <= '0;
          end
        end
        S_RUN: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          res_reg   <= res_next;
          carry_reg <= carry_next;
          if (cnt_reg != LAST_BIT) begin
            cnt_reg <= cnt_reg + CW'(1);
          end else begin
            // Reserved modes report X=0; Zero still tracks the published X
            x_reg     <= is_reserved ? '0 : res_next;
            c_out_reg <= is_arith & carry_next;
            v_reg     <= is_arith & (carry_reg ^ carry_next);
            zero_reg  <= is_reserved ? 1'b1 : (res_next == '0);
            err_reg   <= is_reserved;
          end
        end
        default: ;
      endcase
    end
  end

  assign X     = x_reg;
  assign C_out = c_out_reg;
  assign V     = v_reg;
  assign Zero  = zero_reg;
  assign Err   = err_reg;

endmodule

// File: tb/tb_alu_serial.sv
// Directed and randomized checks of alu_serial (WIDTH=8) against an
// arithmetic reference model.
module tb_alu_serial;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         Start;
  logic [2:0]   Mode;
  logic [W-1:0] A, B;
  logic         C_in;
  logic         Busy, Done, C_out, V, Zero, Err;
  logic [W-1:0] X;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] prev_x = '0;

  alu_serial #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Mode(Mode), .A(A), .B(B),
    .C_in(C_in), .Busy(Busy), .Done(Done), .X(X), .C_out(C_out), .V(V),
    .Zero(Zero), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic on the operands
  task automatic model(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output logic [W-1:0] x, output logic co,
                       output logic v, output logic z, output logic e);
    logic [W:0] s;
    x = '0; co = 1'b0; v = 1'b0; e = 1'b0;
    case (m)
      3'd0: begin
        s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        x  = s[W-1:0]; co = s[W];
        v  = (a[W-1] == b[W-1]) && (x[W-1] != a[W-1]);
      end
      3'd5: begin
        s  = {1'b0, a} + {1'b0, ~b} + 1;
        x  = s[W-1:0]; co = s[W];
        v  = (a[W-1] != b[W-1]) && (x[W-1] != a[W-1]);
      end
      3'd1: x = a & b;
      3'd2: x = a | b;
      3'd3: x = a ^ b;
      3'd4: x = ~(a ^ b);
      default: e = 1'b1;
    endcase
    z = (x == '0);
  endtask

  // Issue one operation and check it to completion. pulse_at >= 0 re-asserts
  // Start with different operands that many cycles into RUN.
  task automatic do_op(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input bit noise, input int pulse_at);
    logic [W-1:0] ex;
    logic eco, ev, ez, ee;
    int j;
    bit seen;
    model(m, a, b, cin, ex, eco, ev, ez, ee);
    @(negedge CLK);
    Start = 1'b1; Mode = m; A = a; B = b; C_in = cin;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    if (noise) begin
      A = W'($urandom); B = W'($urandom); Mode = 3'($urandom); C_in = 1'($urandom);
    end
    seen = 0;
    // j counts clock edges after the Start edge; Done seen at this negedge
    // is sampled by edge j+1 after Start.
    for (j = 0; j < 40; j++) begin
      @(negedge CLK);
      if (j == pulse_at) begin
        Start = 1'b1; A = ~a; B = 8'h5A; Mode = 3'd3;
      end
      if (j == pulse_at + 1) Start = 1'b0;
      if (Done) begin
        seen = 1;
        break;
      end
      chk("busy_run", 32'(Busy), 32'd1);
      chk("x_stable_run", 32'(X), 32'(prev_x));
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(j + 1), 32'(W + 1));
    chk("busy_at_done", 32'(Busy), 32'd0);
    chk("x", 32'(X), 32'(ex));
    chk("c_out", 32'(C_out), 32'(eco));
    chk("v", 32'(V), 32'(ev));
    chk("zero", 32'(Zero), 32'(ez));
    chk("err", 32'(Err), 32'(ee));
    $display("op mode=%0d a=%02h b=%02h cin=%0d -> x=%02h c=%0d v=%0d z=%0d err=%0d (exp %02h)",
             m, a, b, cin, X, C_out, V, Zero, Err, ex);
    prev_x = ex;
    @(negedge CLK);
    chk("done_one_cycle", 32'(Done), 32'd0);
    chk("x_held_idle", 32'(X), 32'(ex));
  endtask

  initial begin
    RST_N = 1'b0; Start = 1'b0; Mode = '0; A = '0; B = '0; C_in = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_x", 32'(X), 32'd0);
    chk("rst_flags", {28'd0, C_out, V, Zero, Err}, 32'd0);
    RST_N = 1'b1;

    do_op(3'd0, 8'hFF, 8'h01, 1'b0, 0, -1);
    do_op(3'd5, 8'h05, 8'h07, 1'b0, 0, -1);
    do_op(3'd5, 8'h80, 8'h01, 1'b1, 0, -1);
    do_op(3'd1, 8'hF0, 8'h3C, 1'b1, 0, -1);
    do_op(3'd2, 8'hF0, 8'h3C, 1'b1, 0, -1);
    do_op(3'd3, 8'hF0, 8'h3C, 1'b0, 0, -1);
    do_op(3'd4, 8'hF0, 8'h3C, 1'b1, 0, -1);
    do_op(3'd6, 8'hAA, 8'h55, 1'b1, 0, -1);
    do_op(3'd0, 8'h10, 8'h20, 1'b1, 0, -1);
    do_op(3'd7, 8'h01, 8'h02, 1'b0, 0, -1);
    do_op(3'd0, 8'h7F, 8'h01, 1'b0, 0, -1);
    do_op(3'd0, 8'h12, 8'h34, 1'b0, 0, 3);

    // Reset in the middle of RUN discards the operation
    @(negedge CLK);
    Start = 1'b1; Mode = 3'd0; A = 8'h55; B = 8'h22; C_in = 1'b0;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("midrst_busy", 32'(Busy), 32'd0);
    chk("midrst_x", 32'(X), 32'd0);
    chk("midrst_done", 32'(Done), 32'd0);
    prev_x = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      chk("midrst_no_done", 32'(Done), 32'd0);
    end
    do_op(3'd0, 8'h21, 8'h43, 1'b1, 0, -1);

    for (int r = 0; r < 40; r++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), 1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
